// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with occupancy count, programmable thresholds,
// standard or first-word-fall-through read, sticky error flags and flush.
module fifo_sync_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              dout,
    output logic                               dout_valid,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;

    // Explicit wrap so non-power-of-two depths never address past the end
    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr_ok = wr_en && !w_full;
    assign w_rd_ok = rd_en && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_rd_ok) r_rd_ptr <= f_next(r_rd_ptr);
            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && w_wr_ok) r_mem[r_wr_ptr] <= din;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown directly; zero while empty keeps dout defined
            assign dout       = w_empty ? '0 : r_mem[r_rd_ptr];
            assign dout_valid = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_dout_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else if (clr) begin
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_ok;
                    if (w_rd_ok) r_dout <= r_mem[r_rd_ptr];
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Drives three FIFO configurations with shared random traffic and
// compares each against a queue-based reference model.
module tb_fifo_sync_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;

    always #5 clk = ~clk;

    logic [7:0] a_dout, b_dout, c_dout;
    logic       a_dv, b_dv, c_dv;
    logic       a_full, b_full, c_full;
    logic       a_empty, b_empty, c_empty;
    logic       a_af, b_af, c_af;
    logic       a_ae, b_ae, c_ae;
    logic [4:0] a_cnt, b_cnt;
    logic [3:0] c_cnt;
    logic       a_ovf, b_ovf, c_ovf;
    logic       a_udf, b_udf, c_udf;

    fifo_sync_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(14),
                     .AE_THRESH(2), .FWFT(1'b0)) u_std16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(a_dout), .dout_valid(a_dv), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_cnt), .overflow(a_ovf), .underflow(a_udf));

    fifo_sync_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(14),
                     .AE_THRESH(2), .FWFT(1'b1)) u_fwft16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(b_dout), .dout_valid(b_dv), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_cnt), .overflow(b_ovf), .underflow(b_udf));

    fifo_sync_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(12), .AF_THRESH(10),
                     .AE_THRESH(3), .FWFT(1'b0)) u_std12 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(c_dout), .dout_valid(c_dv), .full(c_full),
        .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
        .count(c_cnt), .overflow(c_ovf), .underflow(c_udf));

    int n_tests = 0;
    int n_fail  = 0;

    int         depth [3] = '{16, 16, 12};
    int         af_t  [3] = '{14, 14, 10};
    int         ae_t  [3] = '{2, 2, 3};
    bit         fw    [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] q     [3][$];
    bit         m_ovf [3];
    bit         m_udf [3];
    bit         m_dv  [3];
    logic [7:0] m_dout[3];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            m_ovf[k]  = 1'b0;
            m_udf[k]  = 1'b0;
            m_dv[k]   = 1'b0;
            m_dout[k] = 8'h00;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int  n;
            bit  wok, rok;
            n = q[k].size();
            if (clr) begin
                q[k].delete();
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
                m_dv[k]  = 1'b0;
            end else begin
                wok = wr_en && (n < depth[k]);
                rok = rd_en && (n > 0);
                if (wr_en && n == depth[k]) m_ovf[k] = 1'b1;
                if (rd_en && n == 0) m_udf[k] = 1'b1;
                m_dv[k] = rok;
                if (rok) m_dout[k] = q[k].pop_front();
                if (wok) q[k].push_back(din);
            end
        end
    endtask

    task automatic check_inst(input int k, input logic [7:0] d,
                              input logic v, input logic f,
                              input logic e, input logic a_f,
                              input logic a_e, input logic [4:0] c,
                              input logic ov, input logic ud);
        int         n;
        logic [7:0] ed;
        logic       ev;
        n = q[k].size();
        if (fw[k]) begin
            ed = (n > 0) ? q[k][0] : 8'h00;
            ev = (n > 0);
        end else begin
            ed = m_dout[k];
            ev = m_dv[k];
        end
        check($sformatf("i%0d count", k), 32'(c), 32'(n));
        check($sformatf("i%0d full", k), 32'(f), 32'(n == depth[k]));
        check($sformatf("i%0d empty", k), 32'(e), 32'(n == 0));
        check($sformatf("i%0d afull", k), 32'(a_f), 32'(n >= af_t[k]));
        check($sformatf("i%0d aempty", k), 32'(a_e), 32'(n <= ae_t[k]));
        check($sformatf("i%0d ovf", k), 32'(ov), 32'(m_ovf[k]));
        check($sformatf("i%0d udf", k), 32'(ud), 32'(m_udf[k]));
        check($sformatf("i%0d dvalid", k), 32'(v), 32'(ev));
        check($sformatf("i%0d dout", k), 32'(d), 32'(ed));
    endtask

    task automatic check_all();
        check_inst(0, a_dout, a_dv, a_full, a_empty, a_af, a_ae,
                   a_cnt, a_ovf, a_udf);
        check_inst(1, b_dout, b_dv, b_full, b_empty, b_af, b_ae,
                   b_cnt, b_ovf, b_udf);
        check_inst(2, c_dout, c_dv, c_full, c_empty, c_af, c_ae,
                   {1'b0, c_cnt}, c_ovf, c_udf);
    endtask

    task automatic cyc(input logic w, input logic r, input logic c,
                       input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        clr   = c;
        din   = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int pw, pr;
        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // fill, overflow attempt, drain, underflow attempt, flush
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        check("std16 full after fill", 32'(a_full), 32'd1);
        check("std16 count after fill", 32'(a_cnt), 32'd16);
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        check("std16 overflow set", 32'(a_ovf), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        check("std16 full rd+wr count", 32'(a_cnt), 32'd15);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("std16 underflow set", 32'(a_udf), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        check("std16 overflow cleared", 32'(a_ovf), 32'd0);

        // empty with both high: write only
        cyc(1'b1, 1'b1, 1'b0, 8'h5A);
        check("fwft16 head after write", 32'(b_dout), 32'h5A);
        check("std16 count empty rd+wr", 32'(a_cnt), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("fwft16 dvalid after pop", 32'(b_dv), 32'd0);

        // steady occupancy of 5 across pointer wrap
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
        check("std12 count steady", 32'(c_cnt), 32'd5);

        for (int p = 0; p < 15; p++) begin
            pw = ($urandom_range(0, 2) * 40) + 10;
            pr = ($urandom_range(0, 2) * 40) + 10;
            for (int i = 0; i < 200; i++)
                cyc(($urandom_range(0, 99) < pw),
                    ($urandom_range(0, 99) < pr),
                    ($urandom_range(0, 99) < 2), 8'($urandom));
        end

        // asynchronous reset mid-stream
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++)
            cyc(($urandom_range(0, 99) < 60),
                ($urandom_range(0, 99) < 40), 1'b0, 8'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
